// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Definitions shared by the iterative multiply/divide sequencer and the ALU
// control decoder.
//   ALU_CTRL_MUL / ALU_CTRL_DIV : ALU control codes served by the sequencer
//   muldiv_state_t              : sequencer state encoding
//   isMulDivCode()              : true when a control code belongs to this block
// ----------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [3:0] ALU_CTRL_MUL = 4'd5;
  localparam logic [3:0] ALU_CTRL_DIV = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } muldiv_state_t;

  function automatic logic isMulDivCode(input logic [3:0] ctrl);
    return (ctrl == ALU_CTRL_MUL) || (ctrl == ALU_CTRL_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer_if
// Bundle between the EX stage (master) and the multiply/divide sequencer
// (slave).
//   start, alu_ctrl, op_a, op_b, flush     : EX stage -> sequencer
//   stall, busy, done, result_lo/hi,
//   div_by_zero                            : sequencer -> EX stage
// Parameter WIDTH: operand width in bits.
// ----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, alu_ctrl, op_a, op_b, flush,
    input  stall, busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, alu_ctrl, op_a, op_b, flush,
    output stall, busy, done, result_lo, result_hi, div_by_zero
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// ----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational conditional two's-complement negate. Used to take operand
// magnitudes and to restore result signs.
//   i_neg : negate i_val when 1, pass through when 0
//   i_val : input value
//   o_val : i_neg ? -i_val : i_val (modulo 2^WIDTH)
// Parameter WIDTH: data width in bits.
// ----------------------------------------------------------------------------
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  // The most negative value maps onto itself, which read as an unsigned
  // magnitude is exactly 2^(WIDTH-1).
  assign o_val = i_neg ? ({WIDTH{1'b0}} - i_val) : i_val;

endmodule

// File: rtl/muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative one-bit-per-cycle multiply (shift-add) and restoring divide for
// the EX stage, including the sequencer that stalls the pipeline until the
// {hi, lo} result is ready.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_sequencer_if.slave (start/alu_ctrl/op_a/op_b/flush in;
//           stall/busy/done/result_lo/result_hi/div_by_zero out)
// Parameter WIDTH: operand width; a full operation iterates WIDTH times.
// Build option MULDIV_EARLY_OUT_EN: multiplication finishes as soon as the
// remaining multiplier bits are all zero.
// ----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_t      r_state;
  muldiv_state_t      w_nextState;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_opB;
  logic               r_negRes;
  logic               r_signA;
  logic               r_isDiv;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_resLo;
  logic [WIDTH-1:0]   r_resHi;

  logic               w_isMul;
  logic               w_isDiv;
  logic               w_isOp;
  logic               w_busy;
  logic               w_accept;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic               w_bZero;
  logic               w_lastIter;
  logic [WIDTH-1:0]   w_mplierNext;
  logic               w_mulFinish;
  logic [WIDTH:0]     w_remShift;
  logic               w_geq;
  logic [WIDTH-1:0]   w_remDiff;
  logic [WIDTH-1:0]   w_remNext;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  assign w_isMul  = (bus.alu_ctrl == ALU_CTRL_MUL);
  assign w_isDiv  = (bus.alu_ctrl == ALU_CTRL_DIV);
  assign w_isOp   = isMulDivCode(bus.alu_ctrl);
  assign w_busy   = (r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIXUP);
  // DONE accepts as well so a dependent mul/div can issue back-to-back.
  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                    bus.start && w_isOp && !bus.flush;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_absA (
    .i_neg(bus.op_a[WIDTH-1]), .i_val(bus.op_a), .o_val(w_absA)
  );
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_absB (
    .i_neg(bus.op_b[WIDTH-1]), .i_val(bus.op_b), .o_val(w_absB)
  );
  assign w_bZero = (w_absB == '0);

  assign w_lastIter   = (r_count == CW'(WIDTH - 1));
  assign w_mplierNext = r_opB >> 1;

`ifdef MULDIV_EARLY_OUT_EN
  assign w_mulFinish = w_lastIter || (w_mplierNext == '0);
`else
  assign w_mulFinish = w_lastIter;
`endif

  // Restoring divide step: r_acc holds {rem, quo}. The partial remainder is
  // shifted left by one with the next dividend bit (top of quo) brought in;
  // it needs WIDTH+1 bits before the trial subtract.
  assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_geq      = (w_remShift >= {1'b0, r_opB});
  assign w_remDiff  = w_remShift[WIDTH-1:0] - r_opB;
  assign w_remNext  = w_geq ? w_remDiff : w_remShift[WIDTH-1:0];

  // Result sign restoration: product and quotient take sign_a ^ sign_b,
  // the remainder follows the dividend.
  muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fixProd (
    .i_neg(r_negRes), .i_val(r_acc), .o_val(w_prodFix)
  );
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fixQuo (
    .i_neg(r_negRes), .i_val(r_acc[WIDTH-1:0]), .o_val(w_quoFix)
  );
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fixRem (
    .i_neg(r_signA), .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val(w_remFix)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A zero divisor skips the iterations entirely, and with
  // early-out a zero multiplier does the same. Flush overrides everything.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          if (w_isDiv) begin
            w_nextState = w_bZero ? ST_FIXUP : ST_DIV;
          end else begin
`ifdef MULDIV_EARLY_OUT_EN
            w_nextState = w_bZero ? ST_FIXUP : ST_MUL;
`else
            w_nextState = ST_MUL;
`endif
          end
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_MUL:   if (w_mulFinish) w_nextState = ST_FIXUP;
      ST_DIV:   if (w_lastIter)  w_nextState = ST_FIXUP;
      ST_FIXUP: w_nextState = ST_DONE;
      default:  w_nextState = ST_IDLE;
    endcase
    if (bus.flush) begin
      w_nextState = ST_IDLE;
    end
  end

  // Datapath. Nothing updates on a flush cycle, so an aborted operation never
  // reaches the result registers. A divide-by-zero preloads r_acc with the
  // final {op_a, all ones} pattern, which FIXUP then copies unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_opB    <= '0;
      r_negRes <= 1'b0;
      r_signA  <= 1'b0;
      r_isDiv  <= 1'b0;
      r_dbz    <= 1'b0;
      r_resLo  <= '0;
      r_resHi  <= '0;
    end else if (!bus.flush) begin
      if (w_accept) begin
        r_count  <= '0;
        r_negRes <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
        r_signA  <= bus.op_a[WIDTH-1];
        r_isDiv  <= w_isDiv;
        r_dbz    <= w_isDiv && w_bZero;
        r_opB    <= w_absB;
        r_mcand  <= {{WIDTH{1'b0}}, w_absA};
        if (w_isDiv && w_bZero) begin
          r_acc <= {bus.op_a, {WIDTH{1'b1}}};
        end else if (w_isDiv) begin
          r_acc <= {{WIDTH{1'b0}}, w_absA};
        end else begin
          r_acc <= '0;
        end
      end else begin
        case (r_state)
          ST_MUL: begin
            if (r_opB[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand <= r_mcand << 1;
            r_opB   <= w_mplierNext;
            r_count <= r_count + 1'b1;
          end
          ST_DIV: begin
            r_acc   <= {w_remNext, r_acc[WIDTH-2:0], w_geq};
            r_count <= r_count + 1'b1;
          end
          ST_FIXUP: begin
            if (r_dbz) begin
              r_resHi <= r_acc[2*WIDTH-1:WIDTH];
              r_resLo <= r_acc[WIDTH-1:0];
            end else if (r_isDiv) begin
              r_resHi <= w_remFix;
              r_resLo <= w_quoFix;
            end else begin
              r_resHi <= w_prodFix[2*WIDTH-1:WIDTH];
              r_resLo <= w_prodFix[WIDTH-1:0];
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // stall also covers the issue cycle, before the FSM has left IDLE/DONE.
  assign bus.stall       = w_busy || (bus.start && w_isOp && !w_busy);
  assign bus.busy        = w_busy;
  assign bus.done        = (r_state == ST_DONE);
  assign bus.result_lo   = r_resLo;
  assign bus.result_hi   = r_resHi;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer. Stimulus pushes the reference
// result and the cycle in which done is due into a queue; a monitor pops and
// compares whenever done is presented. Honours MULDIV_EARLY_OUT_EN.
// ----------------------------------------------------------------------------
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             dbz;
    int               doneCycle;
  } expItem_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cycleCount = 0;
  int   checks = 0;
  int   errors = 0;
  int   stallCycles;
  expItem_t         expQ[$];
  expItem_t         monItem;
  logic [WIDTH-1:0] lastLo = '0;
  logic [WIDTH-1:0] lastHi = '0;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock and a cycle counter used as the timing reference.
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Records one comparison and reports it when it does not hold.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference model in plain signed 64-bit arithmetic; C-style truncating
  // division gives the remainder the sign of the dividend.
  task automatic refModel(input logic [3:0] code, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] lo,
                          output logic [WIDTH-1:0] hi, output logic dbz,
                          output int lat);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint p;
    longint mag;
    int     msb;
    dbz = 1'b0;
    if (code == ALU_CTRL_MUL) begin
      p   = sa * sb;
      lo  = p[31:0];
      hi  = p[63:32];
      lat = WIDTH + 2;
`ifdef MULDIV_EARLY_OUT_EN
      mag = (sb < 0) ? -sb : sb;
      if (mag == 0) begin
        lat = 2;
      end else begin
        msb = 0;
        for (int i = 0; i < WIDTH; i++) if (mag[i]) msb = i;
        lat = 2 + msb + 1;
      end
`endif
    end else if (sb == 0) begin
      lo  = '1;
      hi  = a;
      dbz = 1'b1;
      lat = 2;
    end else begin
      p   = sa / sb;
      lo  = p[31:0];
      p   = sa % sb;
      hi  = p[31:0];
      lat = WIDTH + 2;
    end
  endtask

  // Drives one start cycle; the caller is positioned just after a rising edge.
  task automatic applyStimulus(input logic [3:0] code, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    expItem_t item;
    int       lat;
    bus.start    = 1'b1;
    bus.alu_ctrl = code;
    bus.op_a     = a;
    bus.op_b     = b;
    if (isMulDivCode(code)) begin
      refModel(code, a, b, item.lo, item.hi, item.dbz, lat);
      item.doneCycle = cycleCount + lat;
      expQ.push_back(item);
    end
    #1;
    checkOutput("stallAtIssue", 64'(bus.stall), 64'(isMulDivCode(code)));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Waits for done (bounded), counting stall cycles seen before it.
  task automatic waitDone(output int stallCount);
    stallCount = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        checkOutput("stallInDone", 64'(bus.stall), 64'd0);
        return;
      end
      if (bus.stall) stallCount++;
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("[TB] FAIL doneTimeout actual=no_done required=done_within_200_cycles");
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return WIDTH'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Scoreboard monitor: compares every done pulse with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone actual=done required=no_done cycle=%0d", cycleCount);
      end else begin
        monItem = expQ.pop_front();
        checkOutput("resultLo", 64'(bus.result_lo), 64'(monItem.lo));
        checkOutput("resultHi", 64'(bus.result_hi), 64'(monItem.hi));
        checkOutput("divByZero", 64'(bus.div_by_zero), 64'(monItem.dbz));
        checkOutput("doneCycle", 64'(cycleCount), 64'(monItem.doneCycle));
        lastLo = monItem.lo;
        lastHi = monItem.hi;
      end
    end
  end

  // Directed scenarios, randomized operations, then mid-divide reset.
  initial begin
    logic [3:0] code;
    bus.start    = 1'b0;
    bus.alu_ctrl = '0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.flush    = 1'b0;
    rst_n        = 1'b0;
    #12;
    checkOutput("resetBusy", 64'(bus.busy), 64'd0);
    checkOutput("resetDone", 64'(bus.done), 64'd0);
    checkOutput("resetStall", 64'(bus.stall), 64'd0);
    checkOutput("resetLo", 64'(bus.result_lo), 64'd0);
    checkOutput("resetHi", 64'(bus.result_hi), 64'd0);
    checkOutput("resetDbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    applyStimulus(ALU_CTRL_MUL, 32'd7, -32'sd3);
    waitDone(stallCycles);
    checkOutput("stallCyclesMul", 64'(stallCycles), 64'(WIDTH + 1));
    nextCycle();

    applyStimulus(ALU_CTRL_DIV, -32'sd7, 32'd2);
    waitDone(stallCycles);
    nextCycle();

    applyStimulus(ALU_CTRL_DIV, 32'd100, 32'd0);
    waitDone(stallCycles);
    checkOutput("stallCyclesDbz", 64'(stallCycles), 64'd1);
    nextCycle();

    applyStimulus(ALU_CTRL_MUL, 32'h0001_0000, 32'h0001_0000);
    repeat (9) nextCycle();
    bus.flush = 1'b1;
    void'(expQ.pop_back());
    nextCycle();
    bus.flush = 1'b0;
    checkOutput("flushBusy", 64'(bus.busy), 64'd0);
    checkOutput("flushDone", 64'(bus.done), 64'd0);
    checkOutput("flushKeepLo", 64'(bus.result_lo), 64'(lastLo));
    checkOutput("flushKeepHi", 64'(bus.result_hi), 64'(lastHi));
    applyStimulus(ALU_CTRL_MUL, 32'd3, 32'd4);
    waitDone(stallCycles);
    nextCycle();

    applyStimulus(ALU_CTRL_MUL, $urandom(), $urandom());
    waitDone(stallCycles);
    applyStimulus(ALU_CTRL_DIV, 32'd20, 32'd6);
    waitDone(stallCycles);
    nextCycle();

    applyStimulus(4'd2, 32'd1, 32'd2);
    repeat (3) nextCycle();
    checkOutput("addIgnoredBusy", 64'(bus.busy), 64'd0);

    applyStimulus(ALU_CTRL_MUL, 32'd5, 32'd1);
    waitDone(stallCycles);
    nextCycle();
    applyStimulus(ALU_CTRL_DIV, 32'h8000_0000, '1);
    waitDone(stallCycles);
    nextCycle();
    applyStimulus(ALU_CTRL_MUL, 32'h8000_0000, 32'h8000_0000);
    waitDone(stallCycles);
    nextCycle();
    applyStimulus(ALU_CTRL_DIV, 32'd7, -32'sd2);
    waitDone(stallCycles);
    nextCycle();

    for (int n = 0; n < 25; n++) begin
      code = ($urandom_range(0, 1) == 0) ? ALU_CTRL_MUL : ALU_CTRL_DIV;
      applyStimulus(code, pickOperand(), pickOperand());
      waitDone(stallCycles);
      nextCycle();
    end

    applyStimulus(ALU_CTRL_DIV, 32'd1000, 32'd7);
    repeat (4) nextCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetBusy", 64'(bus.busy), 64'd0);
    checkOutput("midResetStall", 64'(bus.stall), 64'd0);
    checkOutput("midResetDone", 64'(bus.done), 64'd0);
    checkOutput("midResetLo", 64'(bus.result_lo), 64'd0);
    checkOutput("midResetHi", 64'(bus.result_hi), 64'd0);
    checkOutput("midResetDbz", 64'(bus.div_by_zero), 64'd0);
    expQ.delete();
    lastLo = '0;
    lastHi = '0;
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(ALU_CTRL_MUL, -32'sd3, 32'd4);
    waitDone(stallCycles);
    repeat (5) nextCycle();
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide engine plus its sequencer for the EX stage.
- Accepts ALU control codes 5 (mul) and 4 (div), runs one bit per cycle, then returns the {hi, lo} result.
- Drives `stall` so the pipeline holds the issuing instruction until `done`.
- All other ALU codes stay in the single-cycle ALU; this block ignores them.

Parameters:
- WIDTH, 32, operand width in bits; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  EX stage presents a valid instruction this cycle
- alu_ctrl  in  4  ALU control code; 5 = mul, 4 = div
- op_a  in  WIDTH  rs operand (multiplicand / dividend), two's complement
- op_b  in  WIDTH  rt operand (multiplier / divisor), two's complement
- flush  in  1  pipeline flush; aborts any operation in flight
- stall  out  1  hold IF/ID/EX this cycle
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; result valid
- result_lo  out  WIDTH  mul: low product word; div: quotient
- result_hi  out  WIDTH  mul: high product word; div: remainder
- div_by_zero  out  1  sticky for the last op; set when divisor = 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, div_by_zero, result_lo, result_hi, all internal registers = 0.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- Accept condition: state IDLE or DONE, start=1, alu_ctrl ∈ {4,5}, flush=0.
  - On accept, latch |op_a|, |op_b| and the result sign bits; clear counter and div_by_zero.
  - Go to MUL (code 5) or DIV (code 4).
- Not accepted: start with any other code, or start while in MUL/DIV/FIXUP.
- MUL (left-shift add):
  - 2W accumulator; multiplicand register 2W, shifted left each cycle; multiplier register shifted right.
  - Each cycle add the multiplicand when multiplier[0]=1.
  - After WIDTH cycles go to FIXUP.
- DIV (restoring):
  - Each cycle shift {rem, quo} left, trial-subtract |divisor|, set the quotient bit if the result is non-negative, else restore.
  - After WIDTH cycles go to FIXUP.
  - Divisor = 0 at accept: skip DIV and go directly to FIXUP. Set div_by_zero=1, quotient = all ones, remainder = op_a unchanged.
- FIXUP:
  - mul: negate the 2W product if sign_a XOR sign_b.
  - div: negate the quotient if sign_a XOR sign_b; remainder takes the sign of the dividend.
  - Register result_hi/lo; go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next state IDLE, or a new op if accepted the same cycle (back-to-back allowed).
- Latency: accept edge, then WIDTH compute edges, then FIXUP edge; done is visible WIDTH+2 cycles after start was sampled. Divide-by-zero takes 2 cycles.
- busy: 1 in MUL, DIV, FIXUP.
- stall (combinational): busy OR (start AND alu_ctrl ∈ {4,5} AND state ∉ {MUL, DIV, FIXUP}). It is low in the DONE cycle so the instruction retires.
- result_lo/hi hold their value until the next FIXUP; they are not cleared in IDLE.
- flush: next edge forces IDLE from any state. No done pulse; results keep their previous values. flush has priority over accept.
- Arithmetic widths:
  - |−2^(W−1)| is handled as an unsigned W-bit magnitude.
  - −2^(W−1) / −1 gives quotient 0x8000_0000 (wrap) and remainder 0; no flag.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: in MUL, when the remaining multiplier register = 0, go to FIXUP immediately. Latency is 2 + (index of the highest set bit of |op_b|) + 1 cycles; multiplier 0 takes 2 cycles. DIV is unchanged.
- Undefined: fixed WIDTH iterations for every op.

Decomposition:
- Package muldiv_pkg holds:
  - constants ALU_CTRL_MUL=4'd5 and ALU_CTRL_DIV=4'd4, shared with the ALU control decoder;
  - state enum muldiv_state_t.
- Sub-module muldiv_sign_fix: combinational conditional two's-complement negate, parameterised width. Used for operand abs and result fixup.

Test Plan:
- op_a=7, op_b=−3, code 5 → done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall high for cycles 0–33.
- op_a=−7, op_b=2, code 4 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0.
- op_a=100, op_b=0, code 4 → done at cycle 2; lo=0xFFFFFFFF, hi=100, div_by_zero=1.
- Start mul 0x10000×0x10000, then flush at cycle 10 → IDLE at cycle 11, no done; previous results unchanged. The next mul 3×4 gives lo=12, hi=0.
- Back-to-back: a new div 20/6 is started in the DONE cycle of a mul → accepted, lo=3, hi=2; start with code 2 (add) → stall=0, no activity.
- With MULDIV_EARLY_OUT_EN: 5×1 → done at cycle 3, lo=5. Without it: done at cycle 34. Also assert rst_n low mid-DIV → all outputs 0 immediately.
